// File: rtl/dsp_mac_sequencer.sv
// Sequences sample/coef pairs into one DSP48A1 slice (A1/B1/M/P/OPMODE registered)
// and returns the N_TAPS-term signed dot product once the slice pipeline drains.
module dsp_mac_sequencer #(
  parameter int N_TAPS   = 4,
  parameter int PIPE_LAT = 3,
  parameter int CNT_W    = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_sample,
  input  logic [17:0] in_coef,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [7:0]  dsp_opmode,
  input  logic [47:0] dsp_p,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [47:0] res_data,
  output logic        busy
);

  localparam int DRN_W = $clog2(PIPE_LAT + 1) + 1;
  localparam logic [7:0] OPM_ZERO = 8'h00;
  localparam logic [7:0] OPM_LOAD = 8'h01;
  localparam logic [7:0] OPM_ACC  = 8'h09;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT);

  typedef enum logic [1:0] {S_ACC, S_DRAIN, S_HOLD} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DRN_W-1:0] r_drn;
  logic             r_in_ready;
  logic [17:0]      r_a, r_b;
  logic [7:0]       r_tag;
  logic [7:0]       r_opmode;
  logic             r_res_valid;
  logic [47:0]      r_res_data;
  logic             w_accept;

  assign w_accept = in_valid && r_in_ready;

  // r_tag travels with r_a/r_b; dsp_opmode replays it one cycle later so the
  // slice's OPMODE register lines up with the product leaving MREG.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_ACC;
      r_cnt       <= '0;
      r_drn       <= '0;
      r_in_ready  <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_tag       <= OPM_ZERO;
      r_opmode    <= OPM_ZERO;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_opmode <= r_tag;
      case (r_state)
        S_ACC: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_a   <= in_sample;
            r_b   <= in_coef;
            r_tag <= (r_cnt == '0) ? OPM_LOAD : OPM_ACC;
            if (r_cnt == LAST_TAP) begin
              r_cnt      <= '0;
              r_drn      <= '0;
              r_in_ready <= 1'b0;
              r_state    <= S_DRAIN;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else begin
            r_a   <= '0;
            r_b   <= '0;
            r_tag <= (r_cnt == '0) ? OPM_ZERO : OPM_ACC;
          end
        end
        S_DRAIN: begin
          r_a   <= '0;
          r_b   <= '0;
          r_tag <= OPM_ACC;
          // last product reaches P after PIPE_LAT+1 cycles in DRAIN
          if (r_drn == DRN_LAST) begin
            r_res_data  <= dsp_p;
            r_res_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_drn <= r_drn + DRN_W'(1);
          end
        end
        S_HOLD: begin
          r_a   <= '0;
          r_b   <= '0;
          r_tag <= OPM_ACC;
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_ACC;
          end
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign dsp_a      = r_a;
  assign dsp_b      = r_b;
  assign dsp_opmode = r_opmode;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign busy       = (r_state != S_ACC) || (r_cnt != '0);

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural DSP48A1 slice on dsp_p plus a
// queue of expected dot products popped on each result transfer.
module tb_dsp_mac_sequencer;

  localparam int PIPE_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] in_sample = '0;
  logic [17:0] in_coef = '0;
  logic [17:0] dsp_a, dsp_b;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [47:0] res_data;
  logic        busy;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  int res_cyc = 0;
  longint exp_acc = 0;
  logic [47:0] exp_q[$];

  dsp_mac_sequencer #(.N_TAPS(4), .PIPE_LAT(PIPE_LAT), .CNT_W(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .in_coef(in_coef), .dsp_a(dsp_a), .dsp_b(dsp_b),
    .dsp_opmode(dsp_opmode), .dsp_p(dsp_p), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slice model: A1REG/B1REG -> MREG -> PREG, OPMODE registered once
  logic signed [17:0] s_a1, s_b1;
  logic signed [35:0] s_m;
  logic        [7:0]  s_opm;
  logic signed [47:0] s_p;
  logic signed [47:0] s_x, s_z;
  assign s_x   = (s_opm[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'sd0;
  assign s_z   = (s_opm[3:2] == 2'b10) ? s_p : 48'sd0;
  assign dsp_p = s_p;
  always @(posedge clk) begin
    if (rst) begin
      s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_opm <= '0; s_p <= '0;
    end else begin
      s_a1  <= dsp_a;
      s_b1  <= dsp_b;
      s_m   <= s_a1 * s_b1;
      s_opm <= dsp_opmode;
      s_p   <= s_x + s_z;
    end
  end

  task automatic drive_pair(input logic signed [17:0] s, input logic signed [17:0] c);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_sample = s; in_coef = c;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++;
      $display("FAIL accept_timeout: in_ready=%0b want 1", in_ready);
    end
    acc_cyc = cyc;
    exp_acc += longint'(s) * longint'(c);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_expected();
    exp_q.push_back(exp_acc[47:0]);
    exp_acc = 0;
  endtask

  task automatic wait_result(input string name);
    int n;
    logic [47:0] e;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    total++;
    if (!res_valid) $display("FAIL %s_timeout: res_valid=0 want 1", name);
    else if (exp_q.size() == 0) $display("FAIL %s_unexpected: res_data=%0d want none", name, res_data);
    else begin
      res_cyc = cyc;
      e = exp_q.pop_front();
      if (res_data !== e) $display("FAIL %s_data: got %0d want %0d", name, $signed(res_data), $signed(e));
      else passed++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    total++;
    if (res_valid !== 1'b0) $display("FAIL %s_release: res_valid=%0b want 0", name, res_valid);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total += 7;
    if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b want 0", in_ready); else passed++;
    if (dsp_a !== 18'd0) $display("FAIL rst_dsp_a: got %0h want 0", dsp_a); else passed++;
    if (dsp_b !== 18'd0) $display("FAIL rst_dsp_b: got %0h want 0", dsp_b); else passed++;
    if (dsp_opmode !== 8'h00) $display("FAIL rst_opmode: got %0h want 00", dsp_opmode); else passed++;
    if (res_valid !== 1'b0) $display("FAIL rst_res_valid: got %0b want 0", res_valid); else passed++;
    if (res_data !== 48'd0) $display("FAIL rst_res_data: got %0h want 0", res_data); else passed++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %0b want 1", in_ready); else passed++;
  endtask

  task automatic test_basic();
    res_ready = 1'b1;
    drive_pair(18'sd1, 18'sd2);
    total++;
    if (busy !== 1'b1) $display("FAIL basic_busy_acc: got %0b want 1", busy); else passed++;
    drive_pair(18'sd3, 18'sd4);
    drive_pair(18'sd5, 18'sd6);
    drive_pair(18'sd7, 18'sd8);
    push_expected();
    total += 2;
    if (busy !== 1'b1) $display("FAIL basic_busy_drain: got %0b want 1", busy); else passed++;
    if (in_ready !== 1'b0) $display("FAIL basic_in_ready_drain: got %0b want 0", in_ready); else passed++;
    wait_result("basic");
    total += 2;
    if (res_cyc - acc_cyc !== PIPE_LAT + 2)
      $display("FAIL basic_latency: got %0d want %0d", res_cyc - acc_cyc, PIPE_LAT + 2);
    else passed++;
    if (busy !== 1'b0) $display("FAIL basic_busy_idle: got %0b want 0", busy); else passed++;
  endtask

  task automatic test_signed();
    drive_pair(-18'sd1, 18'sd3);
    drive_pair(18'sd2, -18'sd5);
    drive_pair(-18'sd4, -18'sd4);
    drive_pair(18'sd0, 18'sd9);
    push_expected();
    wait_result("signed_mix");
    for (int i = 0; i < 4; i++) drive_pair(-18'sd131072, -18'sd131072);
    push_expected();
    wait_result("signed_max");
  endtask

  task automatic test_bubbles();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dsp_opmode !== 8'h00) $display("FAIL bubble_opmode_zero: got %0h want 00", dsp_opmode); else passed++;
    drive_pair(18'sd1, 18'sd2);
    repeat (2) @(posedge clk);
    drive_pair(18'sd3, 18'sd4);
    repeat (2) @(posedge clk);
    drive_pair(18'sd5, 18'sd6);
    repeat (2) @(posedge clk);
    drive_pair(18'sd7, 18'sd8);
    push_expected();
    wait_result("bubbles");
  endtask

  task automatic test_back_pressure();
    int n, bad;
    logic [47:0] held;
    res_ready = 1'b0;
    drive_pair(18'sd1, 18'sd2);
    drive_pair(18'sd3, 18'sd4);
    drive_pair(18'sd5, 18'sd6);
    drive_pair(18'sd7, 18'sd8);
    push_expected();
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    held = res_data;
    in_valid = 1'b1; in_sample = 18'sd1; in_coef = 18'sd1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== held || in_ready !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL bp_hold_stable: %0d bad cycles want 0", bad); else passed++;
    in_valid = 1'b0;
    wait_result("bp_first");
    for (int i = 0; i < 4; i++) drive_pair(18'sd1, 18'sd1);
    push_expected();
    wait_result("bp_second");
  endtask

  task automatic test_reset_mid();
    int bad;
    drive_pair(18'sd5, 18'sd5);
    drive_pair(18'sd5, 18'sd5);
    exp_acc = 0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL rstmid_no_result: %0d cycles res_valid=1 want 0", bad); else passed++;
    for (int i = 0; i < 4; i++) drive_pair(18'sd2, 18'sd2);
    push_expected();
    wait_result("rstmid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_bubbles();
    test_back_pressure();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) $display("FAIL leftover_results: %0d queued want 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
